ascon_encryption: RTL and testbench

ASCON_ENCRYPTION -- requirements
Module: ascon_encryption

---
 rtl/ascon_encryption_pkg.sv | 55 +++++
 rtl/ascon_encryption_round.sv | 51 +++++
 rtl/ascon_encryption.sv | 208 ++++++++++++++++++++
 tb/tb_ascon_encryption.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ascon_encryption_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ascon_encryption_pkg
// Purpose  : Shared constants and helpers for the Ascon AEAD / hash core:
//            AEAD IV, precomputed hash initial state, round-constant table,
//            pad word, permutation round counts, mode encoding, and small
//            64-bit word helpers.
// Ports    : none (package)
// Revision : 1.0  initial release
// ============================================================================
package ascon_encryption_pkg;

    // Ascon-128 IV: k=128, r=64, a=12, b=6
    localparam logic [63:0]  c_iv        = 64'h80400c0600000000;

    // Ascon-Hash state after p^12 of IV 0x00400c0000000100 || 0^256
    localparam logic [319:0] c_hash_init = {64'hee9398aadb67f03d,
                                            64'h8bb21831c60f1002,
                                            64'hb48a92db98d5da62,
                                            64'h43189921b8f8e3e8,
                                            64'h348fa5c9d525e140};

    localparam logic [63:0]  c_pad       = 64'h8000000000000000;

    localparam int unsigned  c_rounds_a  = 12;
    localparam int unsigned  c_rounds_b  = 6;

    // Round constant i = 0xf0 - i*0x0f; p^6 uses entries 6..11
    localparam logic [7:0]   c_rc [0:11] = '{8'hf0, 8'he1, 8'hd2, 8'hc3,
                                             8'hb4, 8'ha5, 8'h96, 8'h87,
                                             8'h78, 8'h69, 8'h5a, 8'h4b};

    localparam logic [1:0]   c_mode_idle = 2'd0;
    localparam logic [1:0]   c_mode_enc  = 2'd1;
    localparam logic [1:0]   c_mode_dec  = 2'd2;
    localparam logic [1:0]   c_mode_hash = 2'd3;

    function automatic logic [63:0] ror64(input logic [63:0] x, input int unsigned n);
        return (x >> n) | (x << (64 - n));
    endfunction

    // Block 0 is the most significant 64 bits
    function automatic logic [63:0] blk64(input logic [255:0] v, input logic [1:0] i);
        logic [63:0] r;
        case (i)
            2'd0:    r = v[255:192];
            2'd1:    r = v[191:128];
            2'd2:    r = v[127:64];
            default: r = v[63:0];
        endcase
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ascon_encryption_round.sv
`default_nettype none
// ============================================================================
// Module   : ascon_round
// Purpose  : One combinational Ascon round: constant addition into x2,
//            bitsliced 5-bit S-box layer, linear diffusion layer.
// Ports    : i_state  320-bit state {x0,x1,x2,x3,x4}, x0 in the MSBs
//            i_rc     8-bit round constant
//            o_state  320-bit state after the round
// Revision : 1.0  initial release
// ============================================================================
module ascon_round
    import ascon_encryption_pkg::*;
(
    input  logic [319:0] i_state,
    input  logic [7:0]   i_rc,
    output logic [319:0] o_state
);

    logic [63:0] w_a0, w_a1, w_a2, w_a3, w_a4;
    logic [63:0] w_b0, w_b1, w_b2, w_b3, w_b4;
    logic [63:0] w_s0, w_s1, w_s2, w_s3, w_s4;

    // Constant addition fused with the S-box input XORs
    assign w_a0 = i_state[319:256] ^ i_state[63:0];
    assign w_a1 = i_state[255:192];
    assign w_a2 = i_state[191:128] ^ {56'h0, i_rc} ^ i_state[255:192];
    assign w_a3 = i_state[127:64];
    assign w_a4 = i_state[63:0] ^ i_state[127:64];

    // Chi-like nonlinear step
    assign w_b0 = w_a0 ^ (~w_a1 & w_a2);
    assign w_b1 = w_a1 ^ (~w_a2 & w_a3);
    assign w_b2 = w_a2 ^ (~w_a3 & w_a4);
    assign w_b3 = w_a3 ^ (~w_a4 & w_a0);
    assign w_b4 = w_a4 ^ (~w_a0 & w_a1);

    // S-box output XORs
    assign w_s0 = w_b0 ^ w_b4;
    assign w_s1 = w_b1 ^ w_b0;
    assign w_s2 = ~w_b2;
    assign w_s3 = w_b3 ^ w_b2;
    assign w_s4 = w_b4;

    assign o_state = {w_s0 ^ ror64(w_s0, 19) ^ ror64(w_s0, 28),
                      w_s1 ^ ror64(w_s1, 61) ^ ror64(w_s1, 39),
                      w_s2 ^ ror64(w_s2,  1) ^ ror64(w_s2,  6),
                      w_s3 ^ ror64(w_s3, 10) ^ ror64(w_s3, 17),
                      w_s4 ^ ror64(w_s4,  7) ^ ror64(w_s4, 41)};

endmodule
`default_nettype wire

// File: rtl/ascon_encryption.sv
`default_nettype none
// ============================================================================
// Module   : ascon_encryption
// Purpose  : Single-shot Ascon-128 encrypt / decrypt and Ascon-Hash core,
//            one round per clock, schedule driven by a free-running counter.
// Ports    : clk, rst (async active-low)
//            K, N, A, P, Tin          key, nonce, assoc data, text, tag in
//            Encryption/Decryption/Hashing  mode selects (hash > enc > dec)
//            C, T, count, done, tag_ok      results and status
// Revision : 1.0  initial release
// ============================================================================
module ascon_encryption
    import ascon_encryption_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic [127:0] K,
    input  logic [127:0] N,
    input  logic [255:0] A,
    input  logic [255:0] P,
    input  logic [127:0] Tin,
    input  logic         Encryption,
    input  logic         Decryption,
    input  logic         Hashing,
    output logic [255:0] C,
    output logic [127:0] T,
    output logic [6:0]   count,
    output logic         done,
    output logic         tag_ok
);

    logic [6:0]   r_count;
    logic [1:0]   r_mode;
    logic [127:0] r_key;
    logic [255:0] r_a;
    logic [255:0] r_p;
    logic [127:0] r_tin;
    logic [319:0] r_state;
    logic [255:0] r_cbuf;

    logic [319:0] w_pre;
    logic [319:0] w_post;
    logic [3:0]   w_ri;
    logic         w_run;
    logic         w_cwr;
    logic [1:0]   w_cidx;
    logic [63:0]  w_cblk;
    logic [63:0]  w_pblk;
    logic [6:0]   w_aoff;
    logic [6:0]   w_hoff;
    logic [3:0]   w_amod, w_adiv, w_hmod, w_hdiv;
    logic [127:0] w_tag;

    assign count  = r_count;
    assign w_tag  = r_state[127:0] ^ r_key;

    // AEAD blocks start at count 13 every 6 rounds; hash steps every 12 from 1
    assign w_aoff = r_count - 7'd13;
    assign w_hoff = r_count - 7'd1;
    assign w_amod = 4'(w_aoff % 7'(c_rounds_b));
    assign w_adiv = 4'(w_aoff / 7'(c_rounds_b));
    assign w_hmod = 4'(w_hoff % 7'(c_rounds_a));
    assign w_hdiv = 4'(w_hoff / 7'(c_rounds_a));

    // Schedule: pre-round XORs and round-index selection per count value
    always_comb begin
        w_pre  = r_state;
        w_ri   = 4'd0;
        w_run  = 1'b0;
        w_cwr  = 1'b0;
        w_cidx = 2'd0;
        w_cblk = 64'h0;
        w_pblk = 64'h0;
        case (r_mode)
            c_mode_enc, c_mode_dec: begin
                if (r_count >= 7'd1 && r_count <= 7'd78) begin
                    w_run = 1'b1;
                    if (r_count <= 7'd12)
                        w_ri = 4'(r_count - 7'd1);
                    else if (r_count <= 7'd66)
                        w_ri = w_amod + 4'd6;
                    else
                        w_ri = 4'(r_count - 7'd67);
                end
                if (r_count >= 7'd13 && r_count <= 7'd61 && w_amod == 4'd0) begin
                    if (w_adiv == 4'd0)
                        w_pre[127:0] = r_state[127:0] ^ r_key;
                    if (w_adiv <= 4'd3) begin
                        w_pre[319:256] = r_state[319:256] ^ blk64(r_a, w_adiv[1:0]);
                    end else if (w_adiv == 4'd4) begin
                        w_pre[319:256] = r_state[319:256] ^ c_pad;
                    end else begin
                        if (w_adiv == 4'd5)
                            w_pre[0] = ~r_state[0];
                        w_cidx = 2'(w_adiv - 4'd5);
                        w_pblk = blk64(r_p, w_cidx);
                        w_cwr  = 1'b1;
                        w_cblk = r_state[319:256] ^ w_pblk;
                        // decrypt keeps the ciphertext as the new rate word
                        w_pre[319:256] = (r_mode == c_mode_dec) ? w_pblk : w_cblk;
                    end
                end
                if (r_count == 7'd67) begin
                    w_pre[319:256] = r_state[319:256] ^ c_pad;
                    w_pre[255:128] = r_state[255:128] ^ r_key;
                end
            end
            c_mode_hash: begin
                if (r_count >= 7'd1 && r_count <= 7'd96) begin
                    w_run = 1'b1;
                    w_ri  = w_hmod;
                end
                if (r_count <= 7'd49 && r_count >= 7'd1 && w_hmod == 4'd0) begin
                    if (w_hdiv <= 4'd3)
                        w_pre[319:256] = r_state[319:256] ^ blk64(r_p, w_hdiv[1:0]);
                    else
                        w_pre[319:256] = r_state[319:256] ^ c_pad;
                end
                // squeezes 0..2 land at counts 61/73/85; the last goes straight to C
                if (r_count >= 7'd61 && r_count <= 7'd85 && w_hmod == 4'd0) begin
                    w_cwr  = 1'b1;
                    w_cidx = 2'(w_hdiv - 4'd5);
                    w_cblk = r_state[319:256];
                end
            end
            default: ;
        endcase
    end

    ascon_round u_round (
        .i_state (w_pre),
        .i_rc    (c_rc[w_ri]),
        .o_state (w_post)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count <= 7'd0;
            r_mode  <= c_mode_idle;
            r_key   <= 128'h0;
            r_a     <= 256'h0;
            r_p     <= 256'h0;
            r_tin   <= 128'h0;
            r_state <= 320'h0;
            r_cbuf  <= 256'h0;
            C       <= 256'h0;
            T       <= 128'h0;
            done    <= 1'b0;
            tag_ok  <= 1'b0;
        end else begin
            if (r_count != 7'd127)
                r_count <= r_count + 7'd1;

            if (r_count == 7'd0) begin
                r_key <= K;
                r_a   <= A;
                r_p   <= P;
                r_tin <= Tin;
                if (Hashing) begin
                    r_mode  <= c_mode_hash;
                    r_state <= c_hash_init;
                end else if (Encryption) begin
                    r_mode  <= c_mode_enc;
                    r_state <= {c_iv, K, N};
                end else if (Decryption) begin
                    r_mode  <= c_mode_dec;
                    r_state <= {c_iv, K, N};
                end else begin
                    r_mode  <= c_mode_idle;
                    r_state <= 320'h0;
                end
            end else if (w_run) begin
                r_state <= w_post;
            end

            if (w_cwr) begin
                case (w_cidx)
                    2'd0:    r_cbuf[255:192] <= w_cblk;
                    2'd1:    r_cbuf[191:128] <= w_cblk;
                    2'd2:    r_cbuf[127:64]  <= w_cblk;
                    default: r_cbuf[63:0]    <= w_cblk;
                endcase
            end

            if (r_count == 7'd79 && (r_mode == c_mode_enc || r_mode == c_mode_dec)) begin
                done <= 1'b1;
                if (r_mode == c_mode_enc) begin
                    C      <= r_cbuf;
                    T      <= w_tag;
                    tag_ok <= 1'b0;
                end else begin
                    C      <= (w_tag == r_tin) ? r_cbuf : 256'h0;
                    T      <= 128'h0;
                    tag_ok <= (w_tag == r_tin);
                end
            end

            if (r_count == 7'd97 && r_mode == c_mode_hash) begin
                done   <= 1'b1;
                C      <= {r_cbuf[255:64], r_state[319:256]};
                T      <= 128'h0;
                tag_ok <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ascon_encryption.sv
`default_nettype none
// ============================================================================
// Module   : tb_ascon_encryption
// Purpose  : Directed self-checking bench for ascon_encryption. Expected
//            ciphertext, tag and digest come from a behavioural Ascon model
//            written as plain software-style functions.
// Revision : 1.0  initial release
// ============================================================================
module tb_ascon_encryption;

    logic         clk;
    logic         rst;
    logic [127:0] K, N, Tin;
    logic [255:0] A, P;
    logic         Encryption, Decryption, Hashing;
    logic [255:0] C;
    logic [127:0] T;
    logic [6:0]   count;
    logic         done, tag_ok;

    int checks = 0;
    int errors = 0;

    ascon_encryption dut (
        .clk        (clk),
        .rst        (rst),
        .K          (K),
        .N          (N),
        .A          (A),
        .P          (P),
        .Tin        (Tin),
        .Encryption (Encryption),
        .Decryption (Decryption),
        .Hashing    (Hashing),
        .C          (C),
        .T          (T),
        .count      (count),
        .done       (done),
        .tag_ok     (tag_ok)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic logic [63:0] m_ror(input logic [63:0] x, input int n);
        return (x >> n) | (x << (64 - n));
    endfunction

    function automatic logic [319:0] m_perm(input logic [319:0] s, input int nr);
        logic [63:0] x0, x1, x2, x3, x4, t0, t1, t2, t3, t4;
        {x0, x1, x2, x3, x4} = s;
        for (int r = 12 - nr; r < 12; r++) begin
            x2 ^= 64'(240 - 15 * r);
            x0 ^= x4; x4 ^= x3; x2 ^= x1;
            t0 = ~x0 & x1; t1 = ~x1 & x2; t2 = ~x2 & x3; t3 = ~x3 & x4; t4 = ~x4 & x0;
            x0 ^= t1; x1 ^= t2; x2 ^= t3; x3 ^= t4; x4 ^= t0;
            x1 ^= x0; x0 ^= x4; x3 ^= x2; x2 = ~x2;
            x0 ^= m_ror(x0, 19) ^ m_ror(x0, 28);
            x1 ^= m_ror(x1, 61) ^ m_ror(x1, 39);
            x2 ^= m_ror(x2, 1)  ^ m_ror(x2, 6);
            x3 ^= m_ror(x3, 10) ^ m_ror(x3, 17);
            x4 ^= m_ror(x4, 7)  ^ m_ror(x4, 41);
        end
        return {x0, x1, x2, x3, x4};
    endfunction

    task automatic m_aead(input logic [127:0] k, input logic [127:0] n,
                          input logic [255:0] a, input logic [255:0] p, input bit dec,
                          output logic [255:0] c, output logic [127:0] t);
        logic [319:0] s;
        logic [63:0]  pi;
        s = {64'h80400c0600000000, k, n};
        s = m_perm(s, 12);
        s[127:0] ^= k;
        for (int i = 0; i < 4; i++) begin
            s[319:256] ^= a[255 - 64 * i -: 64];
            s = m_perm(s, 6);
        end
        s[319:256] ^= 64'h8000000000000000;
        s = m_perm(s, 6);
        s[0] ^= 1'b1;
        for (int i = 0; i < 4; i++) begin
            pi = p[255 - 64 * i -: 64];
            c[255 - 64 * i -: 64] = s[319:256] ^ pi;
            if (dec) s[319:256] = pi;
            else     s[319:256] ^= pi;
            s = m_perm(s, 6);
        end
        s[319:256] ^= 64'h8000000000000000;
        s[255:128] ^= k;
        s = m_perm(s, 12);
        t = s[127:0] ^ k;
    endtask

    function automatic logic [255:0] m_hash(input logic [255:0] p);
        logic [319:0] s;
        logic [255:0] h;
        s = {64'h00400c0000000100, 256'h0};
        s = m_perm(s, 12);
        for (int i = 0; i < 4; i++) begin
            s[319:256] ^= p[255 - 64 * i -: 64];
            s = m_perm(s, 12);
        end
        s[319:256] ^= 64'h8000000000000000;
        s = m_perm(s, 12);
        for (int i = 0; i < 4; i++) begin
            h[255 - 64 * i -: 64] = s[319:256];
            if (i < 3) s = m_perm(s, 12);
        end
        return h;
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic restart();
        @(negedge clk);
        rst = 1'b0;
        #2;
        rst = 1'b1;
    endtask

    task automatic run_edges(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    logic [255:0] p_orig, exp_c, exp_h, dec_c;
    logic [127:0] exp_t, dec_t;

    initial begin
        K  = {64'd55, 64'd54};
        N  = {64'd55, 64'd54};
        A  = {64'h0102030405060737, 64'h0102030405060720,
              64'h0102030405060735, 64'h0102030405060720};
        p_orig = 256'ha601a28746d4d31c_2ddb00ef83a70874_71654ebc9b16fc41_9c754290bedbac42;
        P  = p_orig;
        Tin = 128'h0;
        Encryption = 1'b1;
        Decryption = 1'b0;
        Hashing    = 1'b0;
        rst = 1'b0;

        m_aead(K, N, A, p_orig, 1'b0, exp_c, exp_t);
        m_aead(K, N, A, exp_c, 1'b1, dec_c, dec_t);
        exp_h = m_hash(256'h0);

        // reset release and first encryption
        #8;
        rst = 1'b1;
        #1;
        check_eq("rst_count", 256'(count), 256'd0);
        check_eq("rst_C", C, 256'h0);
        check_eq("rst_T", 256'(T), 256'h0);
        check_eq("rst_done", 256'(done), 256'd0);
        run_edges(79);
        check_eq("enc_count79", 256'(count), 256'd79);
        check_eq("enc_done79", 256'(done), 256'd0);
        run_edges(1);
        check_eq("enc_count80", 256'(count), 256'd80);
        check_eq("enc_done80", 256'(done), 256'd1);
        check_eq("enc_C", C, exp_c);
        check_eq("enc_T", 256'(T), 256'(exp_t));
        check_eq("enc_tagok", 256'(tag_ok), 256'd0);
        run_edges(5);
        check_eq("enc_done_hold", 256'(done), 256'd1);

        // async reset with live outputs clears immediately
        rst = 1'b0;
        #1;
        check_eq("arst_count", 256'(count), 256'd0);
        check_eq("arst_done", 256'(done), 256'd0);
        check_eq("arst_C", C, 256'h0);
        check_eq("arst_T", 256'(T), 256'h0);

        // decrypt with the correct tag; inputs change after the latch edge
        Encryption = 1'b0;
        Decryption = 1'b1;
        P   = exp_c;
        Tin = exp_t;
        restart();
        run_edges(1);
        P   = 256'h0;
        Tin = 128'h0;
        run_edges(79);
        check_eq("dec_done", 256'(done), 256'd1);
        check_eq("dec_C", C, p_orig);
        check_eq("dec_T", 256'(T), 256'h0);
        check_eq("dec_tagok", 256'(tag_ok), 256'd1);
        check_eq("dec_model_tag", 256'(dec_t), 256'(exp_t));

        // decrypt with a corrupted tag
        P   = exp_c;
        Tin = exp_t ^ 128'h1;
        restart();
        run_edges(79);
        check_eq("bad_done79", 256'(done), 256'd0);
        run_edges(1);
        check_eq("bad_count80", 256'(count), 256'd80);
        check_eq("bad_done", 256'(done), 256'd1);
        check_eq("bad_tagok", 256'(tag_ok), 256'd0);
        check_eq("bad_C", C, 256'h0);

        // hash has priority over encryption
        Hashing    = 1'b1;
        Encryption = 1'b1;
        Decryption = 1'b0;
        P   = 256'h0;
        Tin = 128'h0;
        restart();
        run_edges(97);
        check_eq("hash_count97", 256'(count), 256'd97);
        check_eq("hash_done97", 256'(done), 256'd0);
        run_edges(1);
        check_eq("hash_done", 256'(done), 256'd1);
        check_eq("hash_C", C, exp_h);
        check_eq("hash_T", 256'(T), 256'h0);

        // reset pulse in the middle of an encryption
        Hashing    = 1'b0;
        Encryption = 1'b1;
        P = p_orig;
        restart();
        run_edges(40);
        check_eq("mid_count40", 256'(count), 256'd40);
        rst = 1'b0;
        #1;
        check_eq("mid_rst_count", 256'(count), 256'd0);
        check_eq("mid_rst_done", 256'(done), 256'd0);
        #1;
        rst = 1'b1;
        run_edges(80);
        check_eq("mid_done", 256'(done), 256'd1);
        check_eq("mid_C", C, exp_c);
        check_eq("mid_T", 256'(T), 256'(exp_t));

        // no mode selected: outputs stay zero
        Encryption = 1'b0;
        restart();
        run_edges(100);
        check_eq("idle_count", 256'(count), 256'd100);
        check_eq("idle_done", 256'(done), 256'd0);
        check_eq("idle_C", C, 256'h0);
        check_eq("idle_T", 256'(T), 256'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
